// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Byte format shared by the UART link transmit scheduler and decoder.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Opcodes occupy w_data[2:0]; payload occupies w_data[7:3]
    localparam logic [2:0] OP_SYNC      = 3'b000;
    localparam logic [2:0] OP_KEEPER_LO = 3'b001;
    localparam logic [2:0] OP_KEEPER_HI = 3'b010;
    localparam logic [2:0] OP_SHOT_XLO  = 3'b011;
    localparam logic [2:0] OP_SHOT_XHI  = 3'b100;
    localparam logic [2:0] OP_SHOT_YLO  = 3'b101;
    localparam logic [2:0] OP_SHOT_YHI  = 3'b110;
    localparam logic [2:0] OP_SCORE     = 3'b111;

    localparam logic [4:0] SYNC_SHOOTER_GAME = 5'b11001;
    localparam logic [4:0] SYNC_KEEPER_GAME  = 5'b01001;
    localparam logic [4:0] SYNC_IDLE         = 5'b00001;

    // Enum value doubles as the bit index into pending / group_done vectors
    typedef enum logic [1:0] {
        GRP_SYNC   = 2'd0,
        GRP_SCORE  = 2'd1,
        GRP_SHOT   = 2'd2,
        GRP_KEEPER = 2'd3
    } group_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [9:0] keeper_pos;
        logic [9:0] x_shot;
        logic [9:0] y_shot;
        logic [2:0] my_score;
        logic       shot_done;
        logic [4:0] sync_payload;
    } snapshot_t;

    function automatic logic [1:0] grp_last_idx(input group_e grp);
        case (grp)
            GRP_SHOT:   return 2'd3;
            GRP_KEEPER: return 2'd1;
            default:    return 2'd0;
        endcase
    endfunction

    function automatic logic [4:0] sync_payload_of(input logic game_starts,
                                                   input logic local_shooter);
        if (game_starts && local_shooter) return SYNC_SHOOTER_GAME;
        if (game_starts)                  return SYNC_KEEPER_GAME;
        return SYNC_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_mux.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_mux
// Brief  : Builds the idx-th opcode-tagged byte of a group from its snapshot.
// Rev    : 1.0  initial release
// ============================================================================
module uart_frame_mux
    import uart_pkg::*;
(
    input  group_e     group,
    input  logic [1:0] idx,
    input  snapshot_t  snap,
    output logic [7:0] frame
);

    always_comb begin
        frame = 8'h00;
        case (group)
            GRP_SYNC:  frame = {snap.sync_payload, OP_SYNC};
            GRP_SCORE: frame = {1'b0, snap.shot_done, snap.my_score, OP_SCORE};
            GRP_SHOT: begin
                case (idx)
                    2'd0:    frame = {snap.x_shot[4:0], OP_SHOT_XLO};
                    2'd1:    frame = {snap.x_shot[9:5], OP_SHOT_XHI};
                    2'd2:    frame = {snap.y_shot[4:0], OP_SHOT_YLO};
                    default: frame = {snap.y_shot[9:5], OP_SHOT_YHI};
                endcase
            end
            GRP_KEEPER: frame = idx[0] ? {snap.keeper_pos[9:5], OP_KEEPER_HI}
                                       : {snap.keeper_pos[4:0], OP_KEEPER_LO};
            default:    frame = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Arbitrates sync/score/shot/keeper groups and writes their bytes
//          into the UART TX FIFO, at most one write every two cycles.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int SYNC_PERIOD = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_full,
    input  logic       tx_en,
    input  logic       game_starts,
    input  logic       local_shooter,
    input  logic       keeper_req,
    input  logic [9:0] keeper_pos,
    input  logic       shot_req,
    input  logic [9:0] x_shot,
    input  logic [9:0] y_shot,
    input  logic       score_req,
    input  logic [2:0] my_score,
    input  logic       shot_done,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic [3:0] group_done
);

    localparam int               c_TMR_W    = $clog2(SYNC_PERIOD);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SYNC_PERIOD - 1);

    logic [c_TMR_W-1:0] r_timer;
    logic [3:0]         r_pend;
    state_e             r_state;
    group_e             r_group;
    logic [1:0]         r_idx;
    logic [1:0]         r_last;
    snapshot_t          r_snap;
    logic               r_wr_uart;
    logic [7:0]         r_w_data;
    logic               r_busy;
    logic [3:0]         r_group_done;

    logic               w_sync_hit;
    logic [3:0]         w_req;
    logic [3:0]         w_clr;
    state_e             w_state_nxt;
    logic               w_grant;
    group_e             w_grant_grp;
    logic               w_write;
    logic               w_last_write;
    logic [7:0]         w_frame;

    uart_frame_mux u_frame_mux (
        .group (r_group),
        .idx   (r_idx),
        .snap  (r_snap),
        .frame (w_frame)
    );

    always_comb begin
        w_sync_hit   = tx_en && (r_timer == c_TMR_LAST);
        w_req        = {keeper_req, shot_req, score_req, w_sync_hit};
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_grp  = GRP_SYNC;
        w_write      = 1'b0;
        w_last_write = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_en && (|r_pend)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_SEND;
                    if (r_pend[GRP_SYNC])       w_grant_grp = GRP_SYNC;
                    else if (r_pend[GRP_SCORE]) w_grant_grp = GRP_SCORE;
                    else if (r_pend[GRP_SHOT])  w_grant_grp = GRP_SHOT;
                    else                        w_grant_grp = GRP_KEEPER;
                end
            end
            ST_SEND: begin
                // Gating on r_wr_uart spaces writes two cycles apart
                if (!tx_full && !r_wr_uart) begin
                    w_write = 1'b1;
                    if (r_idx == r_last) begin
                        w_last_write = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_clr = w_grant ? (4'b0001 << w_grant_grp) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer      <= '0;
            r_pend       <= 4'b0000;
            r_state      <= ST_IDLE;
            r_group      <= GRP_SYNC;
            r_idx        <= 2'd0;
            r_last       <= 2'd0;
            r_snap       <= '0;
            r_wr_uart    <= 1'b0;
            r_w_data     <= 8'h00;
            r_busy       <= 1'b0;
            r_group_done <= 4'b0000;
        end else begin
            if (!tx_en || w_sync_hit) r_timer <= '0;
            else                      r_timer <= r_timer + c_TMR_W'(1);

            // A request arriving in the grant cycle survives the clear
            r_pend       <= (r_pend & ~w_clr) | w_req;
            r_state      <= w_state_nxt;
            r_wr_uart    <= w_write;
            r_busy       <= (w_state_nxt == ST_SEND) || w_last_write;
            r_group_done <= w_last_write ? (4'b0001 << r_group) : 4'b0000;

            if (w_write) begin
                r_w_data <= w_frame;
                r_idx    <= r_idx + 2'd1;
            end

            if (w_grant) begin
                r_group                <= w_grant_grp;
                r_idx                  <= 2'd0;
                r_last                 <= grp_last_idx(w_grant_grp);
                r_snap.keeper_pos      <= keeper_pos;
                r_snap.x_shot          <= x_shot;
                r_snap.y_shot          <= y_shot;
                r_snap.my_score        <= my_score;
                r_snap.shot_done       <= shot_done;
                r_snap.sync_payload    <= sync_payload_of(game_starts, local_shooter);
            end
        end
    end

    assign wr_uart    = r_wr_uart;
    assign w_data     = r_w_data;
    assign busy       = r_busy;
    assign group_done = r_group_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_scheduler
// Brief  : Scoreboard bench for uart_tx_scheduler with randomized groups.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int SYNC_PERIOD = 16;

    logic       clk = 1'b0;
    logic       rst, tx_full, tx_en, game_starts, local_shooter;
    logic       keeper_req, shot_req, score_req, shot_done;
    logic [9:0] keeper_pos, x_shot, y_shot;
    logic [2:0] my_score;
    logic       wr_uart, busy;
    logic [7:0] w_data;
    logic [3:0] group_done;

    uart_tx_scheduler #(.SYNC_PERIOD(SYNC_PERIOD)) dut (
        .clk(clk), .rst(rst), .tx_full(tx_full), .tx_en(tx_en),
        .game_starts(game_starts), .local_shooter(local_shooter),
        .keeper_req(keeper_req), .keeper_pos(keeper_pos),
        .shot_req(shot_req), .x_shot(x_shot), .y_shot(y_shot),
        .score_req(score_req), .my_score(my_score), .shot_done(shot_done),
        .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .group_done(group_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] done;
        logic       first;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0, errors = 0;
    int         cyc = 0, rel_cyc = 0, last_sync = -1, last_data = 0;
    int         n_sync = 0, n_data = 0;
    logic [7:0] sync_exp = 8'h00;
    logic       first_sync_arm = 1'b0, sync_timing_on = 1'b0, spacing_on = 1'b0;
    logic       full_force = 1'b0, full_rand = 1'b0, prev_full = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] sync_byte(input logic gs, input logic ls);
        int p;
        p = (gs && ls) ? 25 : (gs ? 9 : 1);
        return 8'(p * 8);
    endfunction

    function automatic void push_keeper(input logic [9:0] pos);
        for (int i = 0; i < 2; i++) begin
            int v;
            v = int'(pos) >> (5 * i);
            exp_q.push_back('{data: {v[4:0], 3'(1 + i)},
                              done: (i == 1) ? 4'b1000 : 4'b0000, first: (i == 0)});
        end
    endfunction

    function automatic void push_shot(input logic [9:0] x, input logic [9:0] y);
        for (int i = 0; i < 4; i++) begin
            int v;
            v = ((i < 2) ? int'(x) : int'(y)) >> (5 * (i % 2));
            exp_q.push_back('{data: {v[4:0], 3'(3 + i)},
                              done: (i == 3) ? 4'b0100 : 4'b0000, first: (i == 0)});
        end
    endfunction

    function automatic void push_score(input logic [2:0] s, input logic d);
        exp_q.push_back('{data: {1'b0, d, s, 3'b111}, done: 4'b0010, first: 1'b1});
    endfunction

    // ---------------- clock-side helpers ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        tx_full = full_rand ? ($urandom_range(0, 2) == 0) : full_force;
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            checks++;
            if (wr_uart !== 1'b0 || w_data !== 8'h00 || busy !== 1'b0 || group_done !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: wr=%b data=%h busy=%b done=%b, required all zero",
                         wr_uart, w_data, busy, group_done);
            end
        end else if (wr_uart) begin
            checks++;
            if (prev_full) begin
                errors++;
                $display("FAIL write_while_full: wr_uart=1 after tx_full=1, required no write");
            end
            if (w_data[2:0] == 3'b000) begin
                n_sync++;
                checks++;
                if (w_data !== sync_exp || group_done !== 4'b0001) begin
                    errors++;
                    $display("FAIL sync_byte: data=%h done=%b, required data=%h done=0001",
                             w_data, group_done, sync_exp);
                end
                if (first_sync_arm) begin
                    checks++;
                    first_sync_arm = 1'b0;
                    if (cyc - rel_cyc != 18) begin
                        errors++;
                        $display("FAIL sync_after_reset: %0d cycles, required 18", cyc - rel_cyc);
                    end
                end
                if (sync_timing_on) begin
                    if (last_sync >= 0) begin
                        checks++;
                        if (cyc - last_sync != SYNC_PERIOD) begin
                            errors++;
                            $display("FAIL sync_period: %0d cycles, required %0d",
                                     cyc - last_sync, SYNC_PERIOD);
                        end
                    end
                    last_sync = cyc;
                end
            end else begin
                n_data++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: data=%h done=%b, required no write", w_data, group_done);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (w_data !== mon_e.data || group_done !== mon_e.done) begin
                        errors++;
                        $display("FAIL group_byte: data=%h done=%b, required data=%h done=%b",
                                 w_data, group_done, mon_e.data, mon_e.done);
                    end
                    if (spacing_on && !mon_e.first) begin
                        checks++;
                        if (cyc - last_data != 2) begin
                            errors++;
                            $display("FAIL byte_spacing: %0d cycles, required 2", cyc - last_data);
                        end
                    end
                end
                last_data = cyc;
            end
        end
        prev_full = tx_full;
    end

    // ---------------- stimulus tasks ----------------
    task automatic pulse_reqs(input logic k, input logic sh, input logic sc);
        @(posedge clk); #1;
        keeper_req = k; shot_req = sh; score_req = sc;
        @(posedge clk); #1;
        keeper_req = 1'b0; shot_req = 1'b0; score_req = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_q_le(input int target, input int maxc);
        int n;
        n = 0;
        while (exp_q.size() > target && n < maxc) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() > target) begin
            errors++;
            $display("FAIL progress_timeout: %0d bytes outstanding, required <= %0d", exp_q.size(), target);
        end
    endtask

    task automatic set_sync_inputs(input logic gs, input logic ls);
        tx_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        game_starts = gs; local_shooter = ls;
        sync_exp = sync_byte(gs, ls);
        last_sync = -1;
        tx_en = 1'b1;
    endtask

    task automatic quiet_sync(input int ncyc, input int min_syncs);
        int s0;
        s0 = n_sync;
        sync_timing_on = 1'b1;
        last_sync = -1;
        repeat (ncyc) @(posedge clk);
        #1;
        sync_timing_on = 1'b0;
        checks++;
        if (n_sync - s0 < min_syncs) begin
            errors++;
            $display("FAIL sync_count: %0d syncs, required >= %0d", n_sync - s0, min_syncs);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        logic [9:0] kp, xs, ys;
        rst = 1'b1; tx_en = 1'b1; game_starts = 1'b1; local_shooter = 1'b1;
        keeper_req = 1'b1; shot_req = 1'b1; score_req = 1'b1;
        keeper_pos = 10'h3FF; x_shot = 10'h3FF; y_shot = 10'h3FF; my_score = 3'd7; shot_done = 1'b1;
        tx_full = 1'b0;
        sync_exp = sync_byte(1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0; keeper_req = 1'b0; shot_req = 1'b0; score_req = 1'b0;
        rel_cyc = cyc; first_sync_arm = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (first_sync_arm) begin
            errors++;
            $display("FAIL first_sync_missing: no sync byte, required one 18 cycles after reset");
            first_sync_arm = 1'b0;
        end

        quiet_sync(80, 4);

        // keeper directed: 0x59 then 0xAA, two cycles apart
        spacing_on = 1'b1;
        keeper_pos = 10'h2AB;
        push_keeper(10'h2AB);
        pulse_reqs(1'b1, 1'b0, 1'b0);
        wait_drain(200);

        // shot with keeper raised mid-group and inputs changed after snapshot
        x_shot = 10'd320; y_shot = 10'd400;
        push_shot(10'd320, 10'd400);
        pulse_reqs(1'b0, 1'b1, 1'b0);
        wait_q_le(3, 200);
        kp = 10'($urandom);
        x_shot = 10'($urandom); y_shot = 10'($urandom); keeper_pos = kp;
        push_keeper(kp);
        pulse_reqs(1'b1, 1'b0, 1'b0);
        wait_drain(200);

        // score and shot requested in the same cycle
        my_score = 3'd3; shot_done = 1'b1;
        xs = 10'($urandom); ys = 10'($urandom);
        x_shot = xs; y_shot = ys;
        push_score(3'd3, 1'b1);
        push_shot(xs, ys);
        pulse_reqs(1'b0, 1'b1, 1'b1);
        wait_drain(200);

        // FIFO full for 20 cycles mid-group
        spacing_on = 1'b0;
        xs = 10'($urandom); ys = 10'($urandom);
        x_shot = xs; y_shot = ys;
        push_shot(xs, ys);
        pulse_reqs(1'b0, 1'b1, 1'b0);
        wait_q_le(3, 200);
        full_force = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        full_force = 1'b0;
        wait_drain(200);

        // reset after the second shot byte
        xs = 10'($urandom); ys = 10'($urandom);
        x_shot = xs; y_shot = ys;
        push_shot(xs, ys);
        pulse_reqs(1'b0, 1'b1, 1'b0);
        wait_q_le(2, 200);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n0 = n_data;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (n_data != n0) begin
            errors++;
            $display("FAIL residual_after_reset: %0d data bytes, required 0", n_data - n0);
        end

        // randomized group mixes with random FIFO back-pressure
        for (int it = 0; it < 30; it++) begin
            logic [2:0] m;
            logic [2:0] sc;
            logic       sd;
            m = 3'($urandom_range(1, 7));
            full_rand = ($urandom_range(0, 1) == 1);
            kp = 10'($urandom); xs = 10'($urandom); ys = 10'($urandom);
            sc = 3'($urandom); sd = 1'($urandom);
            keeper_pos = kp; x_shot = xs; y_shot = ys; my_score = sc; shot_done = sd;
            if (m[0]) push_score(sc, sd);
            if (m[1]) push_shot(xs, ys);
            if (m[2]) push_keeper(kp);
            pulse_reqs(m[2], m[1], m[0]);
            wait_drain(400);
            full_rand = 1'b0;
        end

        // sync payload variants
        set_sync_inputs(1'b1, 1'b0);
        quiet_sync(60, 2);
        set_sync_inputs(1'b0, 1'b0);
        quiet_sync(60, 2);

        // link disabled: nothing is written, queued request goes out on enable
        tx_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n0 = n_sync + n_data;
        kp = 10'($urandom);
        keeper_pos = kp;
        pulse_reqs(1'b1, 1'b0, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (n_sync + n_data != n0) begin
            errors++;
            $display("FAIL write_while_disabled: %0d writes, required 0", n_sync + n_data - n0);
        end
        push_keeper(kp);
        tx_en = 1'b1;
        wait_drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
